// File: rtl/cpu_fifo_port_pkg.sv
// ---------------------------------------------------------------------------
// cpu_fifo_port_pkg
//  Shared constants and types for the CPU FIFO port.
//  - CPU_DATA_WIDTH : word width carried by both queues
//  - FIFO_RX_DEPTH  : default RX queue depth (power of two, >= 2)
//  - FIFO_TX_DEPTH  : default TX queue depth (power of two, >= 2)
//  - FifoStatus     : packed status word for debug/status readout
//  - cnt_width()    : occupancy counter width for a given depth
// ---------------------------------------------------------------------------
package cpu_fifo_port_pkg;

  localparam int CPU_DATA_WIDTH = 16;
  localparam int FIFO_RX_DEPTH  = 8;
  localparam int FIFO_TX_DEPTH  = 8;

  typedef struct packed {
    logic empty;
    logic full;
    logic err_underflow;
    logic err_overflow;
  } FifoStatus;

  // Occupancy counter must be able to hold DEPTH itself, hence the extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cpu_fifo_port_sync_fifo.sv
// ---------------------------------------------------------------------------
// cpu_fifo_port_sync_fifo
//  Single-clock first-word-fall-through FIFO.
//  Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push, din  : enqueue request and data (dropped when full, unless a pop
//                happens on the same edge)
//   pop        : dequeue request (ignored when empty)
//   dout       : head word, forced to 0 while empty
//   empty/full : occupancy flags
//   count      : occupancy, $clog2(DEPTH)+1 bits
// ---------------------------------------------------------------------------
module cpu_fifo_port_sync_fifo
  import cpu_fifo_port_pkg::*;
#(
  parameter int DATA_WIDTH = CPU_DATA_WIDTH,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == (AW+1)'(DEPTH));

  // A push into a full queue still succeeds when the head leaves on the
  // same edge; a pop of an empty queue never happens, so push-on-empty with
  // pop requested behaves as a plain push.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Fall-through head; zero while empty so stale words never leak out.
  assign dout  = empty ? '0 : r_mem[r_rd_ptr];
  assign count = r_count;

  // Pointers are exactly AW bits wide, so DEPTH being a power of two makes
  // the natural overflow the modulo-DEPTH wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage has no reset; validity is tracked purely by r_count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/cpu_fifo_port.sv
// ---------------------------------------------------------------------------
// cpu_fifo_port
//  Responder for the CPU FIFO instructions. RX queue: external producer ->
//  CPU loads. TX queue: CPU stores -> external consumer. cpu_rx_empty is the
//  BR_FIFO condition; cpu_rd_data feeds the regfile FIFO input leg.
//  Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   cpu_rd_en / cpu_rd_data       : pop RX / RX head (fall-through, 0 if empty)
//   cpu_rx_empty                  : RX empty
//   cpu_wr_en / cpu_wr_data       : push TX
//   cpu_tx_full                   : TX full (pipeline stall indication)
//   ext_in_valid/_data/_ready     : producer handshake into RX
//   ext_out_valid/_data/_ready    : consumer handshake out of TX
//  Optional (macro CPU_FIFO_PORT_STATS_EN):
//   stats_clr                     : clears the sticky error flags
//   rx_count / tx_count           : queue occupancy
//   err_underflow / err_overflow  : sticky ignored-pop / dropped-push flags
// ---------------------------------------------------------------------------
module cpu_fifo_port
  import cpu_fifo_port_pkg::*;
#(
  parameter int DATA_WIDTH = CPU_DATA_WIDTH,
  parameter int RX_DEPTH   = FIFO_RX_DEPTH,
  parameter int TX_DEPTH   = FIFO_TX_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_rd_en,
  output logic [DATA_WIDTH-1:0] cpu_rd_data,
  output logic                  cpu_rx_empty,
  input  logic                  cpu_wr_en,
  input  logic [DATA_WIDTH-1:0] cpu_wr_data,
  output logic                  cpu_tx_full,
  input  logic                  ext_in_valid,
  input  logic [DATA_WIDTH-1:0] ext_in_data,
  output logic                  ext_in_ready,
  output logic                  ext_out_valid,
  output logic [DATA_WIDTH-1:0] ext_out_data,
  input  logic                  ext_out_ready
`ifdef CPU_FIFO_PORT_STATS_EN
  ,
  input  logic                           stats_clr,
  output logic [cnt_width(RX_DEPTH)-1:0] rx_count,
  output logic [cnt_width(TX_DEPTH)-1:0] tx_count,
  output logic                           err_underflow,
  output logic                           err_overflow
`endif
);

  logic                           w_rx_push;
  logic                           w_rx_empty;
  logic                           w_rx_full;
  logic [cnt_width(RX_DEPTH)-1:0] w_rx_count;
  logic                           w_tx_empty;
  logic                           w_tx_full;
  logic [cnt_width(TX_DEPTH)-1:0] w_tx_count;

  // Ready is held low while rst is asserted so no producer handshake can
  // complete on a reset edge.
  assign ext_in_ready = !rst && !w_rx_full;
  assign w_rx_push    = ext_in_valid && ext_in_ready;

  cpu_fifo_port_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_rx_push),
    .pop   (cpu_rd_en),
    .din   (ext_in_data),
    .dout  (cpu_rd_data),
    .empty (w_rx_empty),
    .full  (w_rx_full),
    .count (w_rx_count)
  );

  // The consumer's ready is the TX pop; the FIFO itself ignores it while
  // empty, which is exactly ext_out_valid=0.
  cpu_fifo_port_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cpu_wr_en),
    .pop   (ext_out_ready),
    .din   (cpu_wr_data),
    .dout  (ext_out_data),
    .empty (w_tx_empty),
    .full  (w_tx_full),
    .count (w_tx_count)
  );

  assign cpu_rx_empty  = w_rx_empty;
  assign cpu_tx_full   = w_tx_full;
  assign ext_out_valid = !w_tx_empty;

`ifdef CPU_FIFO_PORT_STATS_EN
  logic r_err_underflow;
  logic r_err_overflow;

  // A store into a full TX is only dropped if the head is not leaving on
  // the same edge. Clear has priority over a same-cycle set.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      r_err_underflow <= 1'b0;
      r_err_overflow  <= 1'b0;
    end else begin
      if (cpu_rd_en && w_rx_empty)                 r_err_underflow <= 1'b1;
      if (cpu_wr_en && w_tx_full && !ext_out_ready) r_err_overflow  <= 1'b1;
    end
  end

  assign rx_count      = w_rx_count;
  assign tx_count      = w_tx_count;
  assign err_underflow = r_err_underflow;
  assign err_overflow  = r_err_overflow;
`else
  // Occupancy is only exported with the stats option.
  logic w_unused_counts;
  assign w_unused_counts = ^{w_rx_count, w_tx_count};
`endif

endmodule

// File: tb/tb_cpu_fifo_port.sv
// ---------------------------------------------------------------------------
// tb_cpu_fifo_port
//  Queue-based reference model of the FIFO port, compared against the DUT
//  on every falling edge, plus directed scenarios with literal expectations.
// ---------------------------------------------------------------------------
module tb_cpu_fifo_port;
  import cpu_fifo_port_pkg::*;

  localparam int DW = 16;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_rd_en = 1'b0;
  logic [DW-1:0] cpu_rd_data;
  logic          cpu_rx_empty;
  logic          cpu_wr_en = 1'b0;
  logic [DW-1:0] cpu_wr_data = '0;
  logic          cpu_tx_full;
  logic          ext_in_valid = 1'b0;
  logic [DW-1:0] ext_in_data = '0;
  logic          ext_in_ready;
  logic          ext_out_valid;
  logic [DW-1:0] ext_out_data;
  logic          ext_out_ready = 1'b0;
`ifdef CPU_FIFO_PORT_STATS_EN
  logic          stats_clr = 1'b0;
  logic [3:0]    rx_count;
  logic [3:0]    tx_count;
  logic          err_underflow;
  logic          err_overflow;
`endif

  always #5 clk = ~clk;

  cpu_fifo_port dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_rd_en     (cpu_rd_en),
    .cpu_rd_data   (cpu_rd_data),
    .cpu_rx_empty  (cpu_rx_empty),
    .cpu_wr_en     (cpu_wr_en),
    .cpu_wr_data   (cpu_wr_data),
    .cpu_tx_full   (cpu_tx_full),
    .ext_in_valid  (ext_in_valid),
    .ext_in_data   (ext_in_data),
    .ext_in_ready  (ext_in_ready),
    .ext_out_valid (ext_out_valid),
    .ext_out_data  (ext_out_data),
    .ext_out_ready (ext_out_ready)
`ifdef CPU_FIFO_PORT_STATS_EN
    ,
    .stats_clr     (stats_clr),
    .rx_count      (rx_count),
    .tx_count      (tx_count),
    .err_underflow (err_underflow),
    .err_overflow  (err_overflow)
`endif
  );

  int  n_vec = 0;
  int  n_err = 0;
  bit  model_ok = 1'b0;
  logic [DW-1:0] rxq[$];
  logic [DW-1:0] txq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance the reference model by one clock edge using the inputs that are
  // currently applied, then let the DUT take that same edge.
  task automatic tick();
    bit rx_pop, rx_push, tx_pop, tx_push;
    if (rst) begin
      rxq.delete();
      txq.delete();
      model_ok = 1'b1;
    end else begin
      rx_pop  = cpu_rd_en && rxq.size() > 0;
      rx_push = ext_in_valid && rxq.size() < D;
      tx_pop  = ext_out_ready && txq.size() > 0;
      tx_push = cpu_wr_en && (txq.size() < D || tx_pop);
      if (rx_pop)  void'(rxq.pop_front());
      if (rx_push) rxq.push_back(ext_in_data);
      if (tx_pop)  void'(txq.pop_front());
      if (tx_push) txq.push_back(cpu_wr_data);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("rx_empty",  cpu_rx_empty,  rxq.size() == 0);
      chk("rd_data",   cpu_rd_data,   (rxq.size() > 0) ? rxq[0] : 16'h0);
      chk("tx_full",   cpu_tx_full,   txq.size() == D);
      chk("out_valid", ext_out_valid, txq.size() > 0);
      chk("out_data",  ext_out_data,  (txq.size() > 0) ? txq[0] : 16'h0);
      chk("in_ready",  ext_in_ready,  !rst && rxq.size() < D);
`ifdef CPU_FIFO_PORT_STATS_EN
      chk("rx_count",  rx_count,      rxq.size());
      chk("tx_count",  tx_count,      txq.size());
`endif
    end
  end

  logic [DW-1:0] exp_drain [8];
  logic [DW-1:0] seq;

  initial begin
    // Initial reset
    rst = 1'b1;
    tick();
    tick();
    chk("reset_in_ready_low", ext_in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready_high", ext_in_ready, 1'b1);
    chk("reset_rx_empty", cpu_rx_empty, 1'b1);
    chk("reset_out_valid", ext_out_valid, 1'b0);
    chk("reset_rd_data", cpu_rd_data, 16'h0);

    // Latency: word appears only after the accepting edge
    ext_in_valid = 1'b1;
    ext_in_data  = 16'h5A5A;
    chk("lat_before_empty", cpu_rx_empty, 1'b1);
    chk("lat_before_data", cpu_rd_data, 16'h0);
    tick();
    ext_in_valid = 1'b0;
    chk("lat_after_empty", cpu_rx_empty, 1'b0);
    chk("lat_after_data", cpu_rd_data, 16'h5A5A);
    cpu_rd_en = 1'b1;
    tick();
    cpu_rd_en = 1'b0;

    // RX fill and ordered drain
    ext_in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ext_in_data = DW'(i + 1);
      tick();
    end
    ext_in_valid = 1'b0;
    chk("rx_full_ready", ext_in_ready, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("rx_pop_order", cpu_rd_data, 32'(i + 1));
      cpu_rd_en = 1'b1;
      tick();
    end
    cpu_rd_en = 1'b0;
    chk("rx_empty_after_drain", cpu_rx_empty, 1'b1);
    cpu_rd_en = 1'b1;
    tick();
    cpu_rd_en = 1'b0;
    chk("rx_underflow_empty", cpu_rx_empty, 1'b1);
    chk("rx_underflow_data", cpu_rd_data, 16'h0);
`ifdef CPU_FIFO_PORT_STATS_EN
    chk("err_underflow", err_underflow, 1'b1);
`endif

    // TX fill, dropped store, concurrent push+pop on full
    ext_out_ready = 1'b0;
    cpu_wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cpu_wr_data = 16'hA000 + DW'(i);
      tick();
    end
    chk("tx_full_after_8", cpu_tx_full, 1'b1);
    cpu_wr_data = 16'hBEEF;
    tick();
    cpu_wr_en = 1'b0;
    chk("tx_drop_head", ext_out_data, 16'hA000);
`ifdef CPU_FIFO_PORT_STATS_EN
    chk("err_overflow", err_overflow, 1'b1);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    chk("stats_clr", {err_underflow, err_overflow}, 2'b00);
`endif
    cpu_wr_en     = 1'b1;
    cpu_wr_data   = 16'h1234;
    ext_out_ready = 1'b1;
    tick();
    cpu_wr_en     = 1'b0;
    ext_out_ready = 1'b0;
    chk("conc_still_full", cpu_tx_full, 1'b1);
    chk("conc_new_head", ext_out_data, 16'hA001);
    for (int i = 0; i < 7; i++) exp_drain[i] = 16'hA001 + DW'(i);
    exp_drain[7] = 16'h1234;
    ext_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("tx_drain_order", ext_out_data, exp_drain[i]);
      tick();
    end
    ext_out_ready = 1'b0;
    chk("tx_drained_valid", ext_out_valid, 1'b0);
    chk("tx_drained_data", ext_out_data, 16'h0);

    // Randomised streaming across pointer wrap, two occupancy biases
    seq = 16'h0100;
    for (int phase = 0; phase < 4; phase++) begin
      for (int c = 0; c < 60; c++) begin
        ext_in_valid  = ($urandom_range(0, 9) < ((phase % 2 == 0) ? 8 : 3));
        cpu_rd_en     = ($urandom_range(0, 9) < ((phase % 2 == 0) ? 3 : 8));
        cpu_wr_en     = ($urandom_range(0, 9) < ((phase % 2 == 0) ? 8 : 3));
        ext_out_ready = ($urandom_range(0, 9) < ((phase % 2 == 0) ? 3 : 8));
        ext_in_data   = seq;
        cpu_wr_data   = ~seq;
        seq           = seq + 16'd1;
        tick();
      end
    end

    // Reset in the middle of traffic
    ext_in_valid  = 1'b1;
    cpu_wr_en     = 1'b1;
    ext_out_ready = 1'b1;
    cpu_rd_en     = 1'b1;
    rst = 1'b1;
    tick();
    chk("midrst_ready_low", ext_in_ready, 1'b0);
    tick();
    chk("midrst_rx_empty", cpu_rx_empty, 1'b1);
    chk("midrst_out_valid", ext_out_valid, 1'b0);
    ext_in_valid  = 1'b0;
    cpu_wr_en     = 1'b0;
    ext_out_ready = 1'b0;
    cpu_rd_en     = 1'b0;
    rst = 1'b0;
    tick();
    chk("midrst_ready_high", ext_in_ready, 1'b1);
    chk("midrst_data", {cpu_rd_data, ext_out_data}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
